// File: rtl/cpu_pkg.sv
// Shared core definitions: access size encodings, load/store FSM states,
// enable constants and the alignment check used by the load/store unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // True when the byte address is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [2:0] mask_s;
    case (size)
      SZ_B:    mask_s = 3'b000;
      SZ_H:    mask_s = 3'b001;
      SZ_W:    mask_s = 3'b011;
      SZ_D:    mask_s = 3'b111;
      default: mask_s = 3'b111;
    endcase
    return (addr_lo & mask_s) != 3'b000;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: byte-enable mask, store data shift and
// load data shift with sign/zero extension.
module lsu_align
  import cpu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int LANE_W = $clog2(BE_W)
) (
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [BE_W-1:0]   mask_s;
  logic [LANE_W+2:0] bit_shift_s;
  logic [DATA_W-1:0] rd_shift_s;
  logic              sign_s;

  assign bit_shift_s = {lane, 3'b000};
  assign be          = mask_s << lane;
  assign wdata_lane  = wdata << bit_shift_s;
  assign rd_shift_s  = rdata >> bit_shift_s;

  // Unshifted byte-enable pattern for the access size.
  always_comb begin
    case (size)
      SZ_B:    mask_s = BE_W'(8'h01);
      SZ_H:    mask_s = BE_W'(8'h03);
      SZ_W:    mask_s = BE_W'(8'h0F);
      SZ_D:    mask_s = BE_W'(8'hFF);
      default: mask_s = BE_W'(8'h00);
    endcase
  end

  // The extra sign bit in front of the field makes the signed cast do the
  // extension; for a 32-bit bus the word case truncates it away.
  always_comb begin
    sign_s    = 1'b0;
    rdata_ext = '0;
    case (size)
      SZ_B: begin
        sign_s    = !is_unsigned && rd_shift_s[7];
        rdata_ext = DATA_W'($signed({sign_s, rd_shift_s[7:0]}));
      end
      SZ_H: begin
        sign_s    = !is_unsigned && rd_shift_s[15];
        rdata_ext = DATA_W'($signed({sign_s, rd_shift_s[15:0]}));
      end
      SZ_W: begin
        sign_s    = !is_unsigned && rd_shift_s[31];
        rdata_ext = DATA_W'($signed({sign_s, rd_shift_s[31:0]}));
      end
      SZ_D: begin
        sign_s    = 1'b0;
        rdata_ext = rd_shift_s;
      end
      default: begin
        sign_s    = 1'b0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core access, runs a valid/ack transaction with
// data memory and returns aligned load data. Optional macro: LSU_TIMEOUT_EN.
module lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);

  lsu_state_e        state_r, state_s;
  logic              store_r, store_s;
  logic              unsigned_r, unsigned_s;
  logic [1:0]        size_r, size_s;
  logic [LANE_W-1:0] lane_r, lane_s;

  logic              req_ready_r, req_ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic              rsp_err_r, rsp_err_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              busy_r, busy_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [BE_W-1:0]   mem_be_r, mem_be_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;

  logic [LANE_W-1:0] al_lane_s;
  logic [1:0]        al_size_s;
  logic              al_uns_s;
  logic [BE_W-1:0]   al_be_s;
  logic [DATA_W-1:0] al_wdata_s;
  logic [DATA_W-1:0] al_rdata_s;
  logic              illegal_s;
  logic              timeout_s;

  assign illegal_s = is_misaligned(req_addr[2:0], req_size) ||
                     ((req_size == SZ_D) && (DATA_W < 64));

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;

  assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT - 1));

  // Counts ack-less cycles in MEM; idles at zero elsewhere so MEM entry starts clean.
  always_comb begin
    if ((state_r == ST_MEM) && !mem_ack) begin
      wait_cnt_s = wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_s = '0;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_s;
    end
  end
`else
  assign timeout_s = DISABLE;
`endif

  // The aligner sees the live request while idle and the captured one afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_lane_s = req_addr[LANE_W-1:0];
      al_size_s = req_size;
      al_uns_s  = req_unsigned;
    end else begin
      al_lane_s = lane_r;
      al_size_s = size_r;
      al_uns_s  = unsigned_r;
    end
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .lane        (al_lane_s),
    .size        (al_size_s),
    .is_unsigned (al_uns_s),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .be          (al_be_s),
    .wdata_lane  (al_wdata_s),
    .rdata_ext   (al_rdata_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    store_s     = store_r;
    unsigned_s  = unsigned_r;
    size_s      = size_r;
    lane_s      = lane_r;
    mem_addr_s  = mem_addr_r;
    mem_be_s    = mem_be_r;
    mem_wdata_s = mem_wdata_r;
    rsp_err_s   = DISABLE;
    rsp_rdata_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          store_s    = req_store;
          unsigned_s = req_unsigned;
          size_s     = req_size;
          lane_s     = req_addr[LANE_W-1:0];
          if (illegal_s) begin
            state_s   = ST_RESP;
            rsp_err_s = ENABLE;
          end else begin
            state_s     = ST_MEM;
            mem_addr_s  = {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_be_s    = al_be_s;
            mem_wdata_s = al_wdata_s;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_s = ST_RESP;
          if (store_r) begin
            rsp_rdata_s = '0;
          end else begin
            rsp_rdata_s = al_rdata_s;
          end
        end else if (timeout_s) begin
          state_s   = ST_RESP;
          rsp_err_s = ENABLE;
        end else begin
          state_s = ST_MEM;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    mem_req_s   = (state_s == ST_MEM);
    mem_we_s    = (state_s == ST_MEM) && store_s;
    rsp_valid_s = (state_s == ST_RESP);
    busy_s      = (state_s != ST_IDLE);
    req_ready_s = (state_s == ST_IDLE);
  end

  // State, captured request fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      store_r     <= 1'b0;
      unsigned_r  <= 1'b0;
      size_r      <= 2'b00;
      lane_r      <= '0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= '0;
      busy_r      <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_be_r    <= '0;
      mem_wdata_r <= '0;
    end else begin
      state_r     <= state_s;
      store_r     <= store_s;
      unsigned_r  <= unsigned_s;
      size_r      <= size_s;
      lane_r      <= lane_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_rdata_r <= rsp_rdata_s;
      busy_r      <= busy_s;
      mem_req_r   <= mem_req_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_be_r    <= mem_be_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign busy      = busy_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu (32-bit bus) with a variable-wait memory model;
// the timeout scenario runs only when LSU_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata_r = 32'h0;

  logic        ack_r = 1'b0;
  logic        late_ack = 1'b0;
  int          cfg_waits = 0;
  int          wcnt = 0;
  int          req_cycles = 0;
  logic        prev_req = 1'b0;
  logic [3:0]  cap_be = 4'h0;
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic        cap_we = 1'b0;
  bit   [31:0] mem_model [bit [31:0]];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  assign mem_ack = ack_r | late_ack;

  lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks after cfg_waits cycles of mem_req, applies byte-enabled writes.
  always @(negedge clk) begin
    logic [31:0] word;
    if (mem_req) begin
      req_cycles = req_cycles + 1;
      if (!prev_req) begin
        cap_be    = mem_be;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_we    = mem_we;
      end
      if (wcnt >= cfg_waits) begin
        ack_r = 1'b1;
        wcnt  = 0;
        word  = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
          end
          mem_model[mem_addr] = word;
        end else begin
          mem_rdata_r = word;
        end
      end else begin
        ack_r = 1'b0;
        wcnt  = wcnt + 1;
      end
    end else begin
      ack_r = 1'b0;
      wcnt  = 0;
    end
    prev_req = mem_req;
  end

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin
        b = w[8*lane +: 8];
        return uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = w[8*lane +: 16];
        return uns ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return w;
    endcase
  endfunction

  task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int waits,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    cfg_waits = waits;
    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    e = sb_q.pop_front();
    if (lat == 0) begin
      check("rsp_wait_bound", 32'h0, 32'h1);
    end else begin
      check("rsp_latency", lat, e.lat);
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
      check("busy_at_rsp", {31'h0, busy}, 32'h1);
    end
  endtask

  initial begin
    logic [31:0] shadow [4];
    int          rc0;
    int          seen;
    int          wt;
    int          idx;
    logic [1:0]  sz;
    logic [1:0]  lane;
    logic        uns;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;

    // Aligned word store then load.
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 2);
    check("sw_be", {28'h0, cap_be}, 32'hF);
    check("sw_addr", cap_addr, 32'h100);
    check("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check("sw_we", {31'h0, cap_we}, 32'h1);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 2);
    check("lw_we", {31'h0, cap_we}, 32'h0);

    // Byte store to lane 3, signed and unsigned byte loads.
    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h80, 0, 32'h0, 1'b0, 2);
    check("sb_be", {28'h0, cap_be}, 32'h8);
    check("sb_wdata", cap_wdata, 32'h80000000);
    check("sb_addr", cap_addr, 32'h100);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'hFFFFFF80, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h00000080, 1'b0, 2);

    // Half loads at lane 2 with three wait states.
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h80011234, 0, 32'h0, 1'b0, 2);
    do_req(1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 3, 32'hFFFF8001, 1'b0, 5);
    check("lh_be", {28'h0, cap_be}, 32'hC);
    do_req(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 3, 32'h00008001, 1'b0, 5);

    // Error paths never touch memory.
    rc0 = req_cycles;
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b1, 1);
    do_req(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 0, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 0, 32'h0, 1'b1, 1);
    check("err_no_mem_req", req_cycles - rc0, 32'h0);

    // Randomised aligned accesses against a shadow copy.
    for (int i = 0; i < 4; i++) begin
      shadow[i] = $urandom;
      wt = $urandom_range(0, 2);
      do_req(1'b1, 2'd2, 1'b0, 32'h300 + 4*i, shadow[i], wt, 32'h0, 1'b0, wt + 2);
    end
    for (int i = 0; i < 8; i++) begin
      idx  = $urandom_range(0, 3);
      sz   = 2'($urandom_range(0, 2));
      lane = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
      uns  = 1'($urandom_range(0, 1));
      wt   = $urandom_range(0, 3);
      do_req(1'b0, sz, uns, 32'h300 + 4*idx + lane, 32'h0, wt,
             exp_load(shadow[idx], lane, sz, uns), 1'b0, wt + 2);
    end

    // Reset while waiting in MEM abandons the access.
    cfg_waits = 50;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_mem_req", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    check("mid_rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("post_rst_no_rsp", seen, 32'h0);

    // An ack while idle must be ignored.
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_rsp", {31'h0, rsp_valid}, 32'h0);
    check("idle_ack_ready", {31'h0, req_ready}, 32'h1);

`ifdef LSU_TIMEOUT_EN
    rc0 = req_cycles;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1000, 32'h0, 1'b1, 5);
    check("to_req_cycles", req_cycles - rc0, 32'h4);
    check("to_mem_req_low", {31'h0, mem_req}, 32'h0);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    check("to_late_ack_rsp", {31'h0, rsp_valid}, 32'h0);
    check("to_late_ack_ready", {31'h0, req_ready}, 32'h1);
`endif

    check("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
